bus_ic: RTL and testbench

- Parametrised single-master, N-slave memory-mapped interconnect; successor to the fixed two-slave UART/GPIO bus decoder.
- Sits between the CPU load/store unit and the peripherals (UART, GPIO, timer, ...).
- Decodes the slave from a configurable address field and runs a req/ack handshake per slave.
- Returns a registered one-cycle response with an error flag for unmapped addresses and (optionally) unresponsive slaves.

---
 rtl/bus_ic_if.sv | 37 +++
 rtl/bus_ic.sv | 141 ++++++++++++++
 tb/tb_bus_ic.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_ic_if.sv
// bus_ic_if: master-side and slave-side signal bundle of bus_ic.
// Modports: ic (interconnect), master (CPU LSU), slave (peripherals).
interface bus_ic_if #(
  parameter int NUM_SLAVES = 4
);
  logic                      m_req_i;
  logic                      m_we_i;
  logic [31:0]               m_addr_i;
  logic [31:0]               m_wdata_i;
  logic                      m_ready_o;
  logic                      m_resp_o;
  logic [31:0]               m_rdata_o;
  logic                      m_err_o;
  logic [NUM_SLAVES-1:0]     s_req_o;
  logic [NUM_SLAVES-1:0]     s_we_o;
  logic [NUM_SLAVES*32-1:0]  s_addr_o;
  logic [NUM_SLAVES*32-1:0]  s_wdata_o;
  logic [NUM_SLAVES-1:0]     s_ack_i;
  logic [NUM_SLAVES*32-1:0]  s_rdata_i;

  modport ic (
    input  m_req_i, m_we_i, m_addr_i, m_wdata_i,
    input  s_ack_i, s_rdata_i,
    output m_ready_o, m_resp_o, m_rdata_o, m_err_o,
    output s_req_o, s_we_o, s_addr_o, s_wdata_o
  );

  modport master (
    output m_req_i, m_we_i, m_addr_i, m_wdata_i,
    input  m_ready_o, m_resp_o, m_rdata_o, m_err_o
  );

  modport slave (
    input  s_req_o, s_we_o, s_addr_o, s_wdata_o,
    output s_ack_i, s_rdata_i
  );
endinterface

// File: rtl/bus_ic.sv
// bus_ic: single-master N-slave req/ack interconnect, registered response.
// Optional BUS_TIMEOUT_EN: error response after TIMEOUT unacked BUSY cycles.
module bus_ic #(
  parameter int                          NUM_SLAVES = 4,
  parameter int                          SEL_W      = 4,
  parameter logic [NUM_SLAVES*SEL_W-1:0] SLAVE_IDS  = 16'h4312,
  parameter bit                          STRIP_SEL  = 1'b1,
  parameter int                          TIMEOUT    = 16
) (
  input  logic     sys_clk,
  input  logic     sys_reset,
  bus_ic_if.ic     bus
);
  localparam int KW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [31:0] W_MASK =
    ~(32'({SEL_W{1'b1}}) << (32 - SEL_W));

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  state_t                   r_state;
  logic [KW-1:0]            r_k;
  logic                     r_ready;
  logic                     r_resp;
  logic [31:0]              r_rdata;
  logic                     r_err;
  logic [NUM_SLAVES-1:0]    r_sreq;
  logic [NUM_SLAVES-1:0]    r_swe;
  logic [NUM_SLAVES*32-1:0] r_saddr;
  logic [NUM_SLAVES*32-1:0] r_swdata;
`ifdef BUS_TIMEOUT_EN
  logic [15:0]              r_cnt;
`endif

  logic          w_hit;
  logic [KW-1:0] w_idx;
  logic [31:0]   w_addr;

  // Scan downward so the lowest matching index is the last one written.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (bus.m_addr_i[31 -: SEL_W] == SLAVE_IDS[i*SEL_W +: SEL_W]) begin
        w_hit = 1'b1;
        w_idx = KW'(i);
      end
    end
    w_addr = STRIP_SEL ? (bus.m_addr_i & W_MASK) : bus.m_addr_i;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      r_state  <= ST_IDLE;
      r_k      <= '0;
      r_ready  <= 1'b1;
      r_resp   <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_sreq   <= '0;
      r_swe    <= '0;
      r_saddr  <= '0;
      r_swdata <= '0;
`ifdef BUS_TIMEOUT_EN
      r_cnt    <= '0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.m_req_i && r_ready) begin
            r_ready <= 1'b0;
            if (w_hit) begin
              r_state                 <= ST_BUSY;
              r_k                     <= w_idx;
              r_sreq                  <= '0;
              r_sreq[w_idx]           <= 1'b1;
              r_swe                   <= '0;
              r_swe[w_idx]            <= bus.m_we_i;
              r_saddr                 <= '0;
              r_saddr[w_idx*32 +: 32] <= w_addr;
              r_swdata                <= '0;
              r_swdata[w_idx*32 +: 32] <= bus.m_wdata_i;
`ifdef BUS_TIMEOUT_EN
              r_cnt                   <= '0;
`endif
            end else begin
              r_state <= ST_RESP;
              r_resp  <= 1'b1;
              r_err   <= 1'b1;
              r_rdata <= '0;
            end
          end
        end
        ST_BUSY: begin
          if (bus.s_ack_i[r_k]) begin
            r_state  <= ST_RESP;
            r_resp   <= 1'b1;
            r_err    <= 1'b0;
            r_rdata  <= r_swe[r_k] ? 32'h0 : bus.s_rdata_i[r_k*32 +: 32];
            r_sreq   <= '0;
            r_swe    <= '0;
            r_saddr  <= '0;
            r_swdata <= '0;
          end
`ifdef BUS_TIMEOUT_EN
          else if (r_cnt == 16'(TIMEOUT - 1)) begin
            r_state  <= ST_RESP;
            r_resp   <= 1'b1;
            r_err    <= 1'b1;
            r_rdata  <= 32'hDEAD_BEEF;
            r_sreq   <= '0;
            r_swe    <= '0;
            r_saddr  <= '0;
            r_swdata <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
`endif
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_resp  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.m_ready_o = r_ready;
  assign bus.m_resp_o  = r_resp;
  assign bus.m_rdata_o = r_rdata;
  assign bus.m_err_o   = r_err;
  assign bus.s_req_o   = r_sreq;
  assign bus.s_we_o    = r_swe;
  assign bus.s_addr_o  = r_saddr;
  assign bus.s_wdata_o = r_swdata;
endmodule

// File: tb/tb_bus_ic.sv
// tb_bus_ic: directed and random transactions against a decode/response
// model of bus_ic; the bench plays both the master and all slaves.
module tb_bus_ic;
  localparam int          NS  = 4;
  localparam int          SW  = 4;
  localparam logic [15:0] IDS = 16'h4312;
  localparam int          TO  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_ic_if #(.NUM_SLAVES(NS)) bus ();

  bus_ic #(
    .NUM_SLAVES(NS),
    .SEL_W(SW),
    .SLAVE_IDS(IDS),
    .STRIP_SEL(1'b1),
    .TIMEOUT(TO)
  ) u_dut (
    .sys_clk(clk),
    .sys_reset(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [NS*32-1:0] obs,
                     input logic [NS*32-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ref_slave(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if (((int'(IDS) >> (i * SW)) & 15) == int'(a[31:28]))
        return i;
    return -1;
  endfunction

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_ready"}, bus.m_ready_o, 1);
    chk({tag, "_resp"}, bus.m_resp_o, 0);
    chk({tag, "_sreq"}, bus.s_req_o, 0);
  endtask

  // One full transaction; d = BUSY cycles before the ack is raised.
  task automatic txn(input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input int d,
                     input logic [31:0] rd, input bit spur);
    int                 k;
    logic [NS-1:0]      er, ew;
    logic [NS*32-1:0]   ea, eww, garb;
    logic [31:0]        exp_rd;
    logic               exp_err;
    k = ref_slave(a);
    chk("pre_ready", bus.m_ready_o, 1);
    bus.m_req_i   = 1'b1;
    bus.m_we_i    = we;
    bus.m_addr_i  = a;
    bus.m_wdata_i = wd;
    @(negedge clk);
    bus.m_req_i   = 1'($urandom);
    bus.m_we_i    = 1'($urandom);
    bus.m_addr_i  = $urandom;
    bus.m_wdata_i = $urandom;
    if (k < 0) begin
      exp_rd  = 32'h0;
      exp_err = 1'b1;
      chk("miss_resp", bus.m_resp_o, 1);
      chk("miss_err", bus.m_err_o, 1);
      chk("miss_rdata", bus.m_rdata_o, 0);
      chk("miss_sreq", bus.s_req_o, 0);
      chk("miss_ready", bus.m_ready_o, 0);
    end else begin
      er  = NS'(1) << k;
      ew  = we ? er : '0;
      ea  = '0;
      eww = '0;
      ea[k*32 +: 32]  = a & 32'h0FFF_FFFF;
      eww[k*32 +: 32] = wd;
      for (int c = 0; c <= d; c++) begin
        chk("busy_sreq", bus.s_req_o, er);
        chk("busy_swe", bus.s_we_o, ew);
        chk("busy_saddr", bus.s_addr_o, ea);
        chk("busy_swdata", bus.s_wdata_o, eww);
        chk("busy_resp", bus.m_resp_o, 0);
        chk("busy_ready", bus.m_ready_o, 0);
        for (int j = 0; j < NS; j++)
          garb[j*32 +: 32] = $urandom;
        bus.s_rdata_i = garb;
        if (c == d) begin
          bus.s_rdata_i[k*32 +: 32] = rd;
          bus.s_ack_i = er | (spur ? NS'($urandom) : '0);
        end else if (spur && c == d / 2) begin
          bus.s_ack_i = ~er;
        end
        @(negedge clk);
        bus.s_ack_i = '0;
      end
      exp_rd  = we ? 32'h0 : rd;
      exp_err = 1'b0;
      chk("ack_resp", bus.m_resp_o, 1);
      chk("ack_rdata", bus.m_rdata_o, exp_rd);
      chk("ack_err", bus.m_err_o, 0);
      chk("ack_sreq", bus.s_req_o, 0);
      chk("ack_saddr", bus.s_addr_o, 0);
      chk("ack_ready", bus.m_ready_o, 0);
    end
    @(negedge clk);
    bus.m_req_i = 1'b0;
    chk_idle_outs("post");
    chk("hold_rdata", bus.m_rdata_o, exp_rd);
    chk("hold_err", bus.m_err_o, exp_err);
  endtask

  initial begin
    bus.m_req_i   = 1'b0;
    bus.m_we_i    = 1'b0;
    bus.m_addr_i  = '0;
    bus.m_wdata_i = '0;
    bus.s_ack_i   = '0;
    bus.s_rdata_i = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle_outs("rst");
    chk("rst_err", bus.m_err_o, 0);
    chk("rst_rdata", bus.m_rdata_o, 0);
    chk("rst_swe", bus.s_we_o, 0);
    chk("rst_saddr", bus.s_addr_o, 0);
    chk("rst_swdata", bus.s_wdata_o, 0);
    rst = 1'b0;
    @(negedge clk);

    txn(1'b0, 32'h2000_0004, 32'h0, 1, 32'h0000_0041, 1'b0);
    txn(1'b1, 32'h1000_0000, 32'h0000_00A5, 0, 32'h1234_5678, 1'b0);
    txn(1'b0, 32'hF000_0000, 32'h0, 0, 32'h0, 1'b0);
    txn(1'b0, 32'h3000_0010, 32'h0, 7, 32'hCAFE_0003, 1'b1);

    bus.m_req_i  = 1'b1;
    bus.m_we_i   = 1'b0;
    bus.m_addr_i = 32'h4000_0020;
    @(negedge clk);
    bus.m_req_i = 1'b0;
`ifdef BUS_TIMEOUT_EN
    for (int c = 0; c < TO; c++) begin
      chk("to_sreq", bus.s_req_o, 4'b1000);
      chk("to_resp", bus.m_resp_o, 0);
      @(negedge clk);
    end
    chk("to_resp_hi", bus.m_resp_o, 1);
    chk("to_err", bus.m_err_o, 1);
    chk("to_rdata", bus.m_rdata_o, 32'hDEAD_BEEF);
    chk("to_sreq_lo", bus.s_req_o, 0);
    @(negedge clk);
    chk_idle_outs("to_post");
`else
    for (int c = 0; c < 20; c++) begin
      chk("nto_sreq", bus.s_req_o, 4'b1000);
      chk("nto_resp", bus.m_resp_o, 0);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_outs("nto_rst");
`endif

    bus.m_req_i  = 1'b1;
    bus.m_addr_i = 32'h3000_0000;
    @(negedge clk);
    bus.m_req_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_sreq", bus.s_req_o, 4'b0100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_outs("mid_rst");
    chk("mid_saddr", bus.s_addr_o, 0);
    bus.s_ack_i = 4'b0100;
    @(negedge clk);
    bus.s_ack_i = '0;
    chk_idle_outs("mid_rst2");

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = {4'($urandom_range(0, 7)), 28'($urandom)};
      txn(1'($urandom), a, $urandom, int'($urandom_range(0, 4)),
          $urandom, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
